alu_operand_fetch: RTL and testbench
====================================

# alu_operand_fetch

Operand-fetch stage directly upstream of the 32-bit ALU. It accepts instruction words, decodes them into an ALU opcode and destination, and reads a 16-entry register file to produce the ALU `r2`/`r3` operands. A scoreboard guards against read-after-write hazards. A 2-entry output buffer decouples this stage from the ALU. It also owns the architectural register file and flags register, which are written back from the ALU result `r1` and ALU flags.

## Interface

Parameters:
- `LEN`, 32, datapath width (register width, ALU operand width)
- `NREG`, 16, number of registers; register index width is 4 bits (fixed)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction word present
- `in_ready`  out  1  stage accepts `instr` this cycle
- `instr`  in  32  {opcode[31:28], rd[27:24], rs[23:20], rt[19:16], imm_sel[15], imm[14:0]}
- `out_valid`  out  1  head of output buffer valid
- `out_ready`  in  1  ALU/execute side consumes head this cycle
- `opcode`  out  4  ALU opcode of head entry
- `r2`  out  LEN  operand A of head entry (value of rs)
- `r3`  out  LEN  operand B of head entry (value of rt, or sign-extended imm)
- `rd`  out  4  destination register of head entry
- `wb_en`  in  1  writeback strobe from ALU stage
- `wb_rd`  in  4  writeback destination
- `wb_data`  in  LEN  ALU result `r1`
- `wb_flags`  in  4  ALU flags
- `flags_q`  out  4  architectural flags register
- `illegal`  out  1  one-cycle pulse: the accepted instruction had an undefined opcode

## Operation

- Opcode map (matches ALU mux order): 0 add, 1 sub, 2 mult, 3 or, 4 and, 5 xor, 6 left shift, 7 right shift, 8 right rotate. Opcodes 9–15 are illegal.
- Register file: NREG x LEN. Register 0 reads as 0 and ignores writes. Writes occur at the rising edge when `wb_en`=1.
- Operand B: if `imm_sel`=1, `r3` = sign-extend(`imm[14:0]`) to LEN; otherwise `r3` = reg[rt].
- Bypass: if `wb_en` and `wb_rd`==rs (or rt) in the accept cycle and the index is nonzero, the captured operand is `wb_data`, not the stale array value.
- Scoreboard: one busy bit per register.
  - Busy is set on accept of a legal instruction with rd≠0.
  - Busy is cleared on `wb_en` for `wb_rd`.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard: hazard = busy[rs] | (busy[rt] & !imm_sel) | busy[rd]. This is evaluated after applying the same-cycle clear, so a register being written back this cycle is not considered busy.
- Accept: an instruction is accepted when `in_valid & in_ready`, where `in_ready` = (count<2) & !hazard.
  - `in_ready` does not depend on `out_ready`.
  - When `in_valid`=0, `in_ready` reflects count only.
- Legal accepted instruction: pushed into the output buffer as {opcode, rd, r2, r3}.
- Illegal accepted instruction: dropped. No push, no busy update. `illegal`=1 for the next cycle.
- Output buffer: 2-entry FIFO. Pop occurs on `out_valid & out_ready`. Push and pop may occur in the same cycle. The output payload holds its value while `out_valid & !out_ready`.
- Flags: `flags_q` loads `wb_flags` when `wb_en`=1; otherwise it holds.

## Timing

- Reset (async assert, synchronous-safe deassert), all state cleared:
  - count=0, `out_valid`=0
  - `opcode`/`r2`/`r3`/`rd` = 0
  - all registers 0, all busy bits 0
  - `flags_q`=0, `illegal`=0
  - After reset, `in_ready`=1.
- Latency: an instruction accepted at edge N with an empty buffer presents `out_valid`=1 with its payload in the cycle after edge N.
- Writeback at edge N is visible to:
  - register reads and hazard clear in the same cycle (via bypass);
  - the array from cycle N+1.
- Full: count=2 forces `in_ready`=0 regardless of `out_ready`. The first accept is possible in the cycle after a pop.
- Reset mid-operation: buffered entries, pending busy bits and the `illegal` pulse are discarded immediately.

## Test plan

- Write/read: wb_en rd=3 data=0x0000_0010; then `instr` add rd=4 rs=3 rt=3 -> out opcode=0, r2=r3=0x10, rd=4, next cycle.
- Immediate and r0: sub rd=1 rs=0 imm_sel=1 imm=0x7FFF (-1) -> r2=0, r3=0xFFFF_FFFF; a write to reg 0 leaves reads of rs=0 at 0.
- RAW hazard: or rd=5 accepted; then and rs=5 -> `in_ready`=0 until the cycle `wb_en` wb_rd=5 data=0xA5 arrives. That cycle is accepted with r2=0xA5 via bypass.
- Backpressure: `out_ready`=0, three independent instructions -> two accepted, `in_ready`=0 on the third; raise `out_ready` -> entries drained in order, third accepted one cycle after the first pop.
- Illegal and flags: opcode 12 -> `illegal` pulse 1 cycle, no `out_valid`, no busy set; wb_en wb_flags=4'b1010 -> `flags_q`=4'b1010 next cycle.
- Reset mid-operation: assert `rst_n`=0 with 2 entries buffered and reg 5 busy -> `out_valid`=0 immediately, `in_ready`=1 after release, reg reads 0.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand fetch ahead of the ALU: decode, register read with writeback
// bypass, RAW scoreboard and a two-entry output buffer.
module alu_operand_fetch #(
   parameter int LEN  = 32,
   parameter int NREG = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [31:0]    instr,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [3:0]     opcode,
   output logic [LEN-1:0] r2,
   output logic [LEN-1:0] r3,
   output logic [3:0]     rd,
   input  logic           wb_en,
   input  logic [3:0]     wb_rd,
   input  logic [LEN-1:0] wb_data,
   input  logic [3:0]     wb_flags,
   output logic [3:0]     flags_q,
   output logic           illegal
);

   typedef struct packed {
      logic [3:0]     op;
      logic [3:0]     rd;
      logic [LEN-1:0] a;
      logic [LEN-1:0] b;
   } entry_t;

   logic [LEN-1:0] regs_q [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] busy_eff;
   entry_t          mem_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic [1:0]      count_d;
   logic            illegal_q;

   logic [3:0]  f_op;
   logic [3:0]  f_rd;
   logic [3:0]  f_rs;
   logic [3:0]  f_rt;
   logic        f_isel;
   logic [14:0] f_imm;
   logic        legal;
   logic        hazard;
   logic        accept;
   logic        push;
   logic        pop;
   entry_t      push_ent;
   entry_t      head;

   assign f_op   = instr[31:28];
   assign f_rd   = instr[27:24];
   assign f_rs   = instr[23:20];
   assign f_rt   = instr[19:16];
   assign f_isel = instr[15];
   assign f_imm  = instr[14:0];

   function automatic logic [LEN-1:0] rdata(input logic [3:0] idx);
      logic [LEN-1:0] v;
      v = regs_q[idx];
      if (idx == 4'd0) begin
         v = '0;
      end else if (wb_en && wb_rd == idx) begin
         v = wb_data;
      end
      return v;
   endfunction

   assign legal = (f_op <= 4'd8);

   // A register retiring this cycle no longer blocks issue.
   always_comb begin
      clr_mask = '0;
      if (wb_en) begin
         clr_mask = {{(NREG-1){1'b0}}, 1'b1} << wb_rd;
      end
      busy_eff = busy_q & ~clr_mask;
   end

   assign hazard = busy_eff[f_rs]
                 | (busy_eff[f_rt] & ~f_isel)
                 | busy_eff[f_rd];

   assign in_ready = (count_q != 2'd2) & ~(in_valid & hazard);
   assign accept   = in_valid & in_ready;
   assign push     = accept & legal;
   assign pop      = out_valid & out_ready;

   always_comb begin
      push_ent.op = f_op;
      push_ent.rd = f_rd;
      push_ent.a  = rdata(f_rs);
      push_ent.b  = rdata(f_rt);
      if (f_isel) begin
         push_ent.b = {{(LEN-15){f_imm[14]}}, f_imm};
      end
   end

   always_comb begin
      set_mask = '0;
      if (push && f_rd != 4'd0) begin
         set_mask = {{(NREG-1){1'b0}}, 1'b1} << f_rd;
      end
      busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         flags_q <= '0;
      end else if (wb_en) begin
         if (wb_rd != 4'd0) begin
            regs_q[wb_rd] <= wb_data;
         end
         flags_q <= wb_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         count_q   <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         illegal_q <= 1'b0;
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
      end else begin
         busy_q    <= busy_d;
         count_q   <= count_d;
         illegal_q <= accept & ~legal;
         if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (count_q != 2'd0);
   assign opcode    = head.op;
   assign rd        = head.rd;
   assign r2        = head.a;
   assign r3        = head.b;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed scenarios with an output
// scoreboard popped whenever the buffer head is consumed.
module tb_alu_operand_fetch;

   localparam int LEN = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [31:0]    instr;
   logic           out_valid;
   logic           out_ready;
   logic [3:0]     opcode;
   logic [LEN-1:0] r2;
   logic [LEN-1:0] r3;
   logic [3:0]     rd;
   logic           wb_en;
   logic [3:0]     wb_rd;
   logic [LEN-1:0] wb_data;
   logic [3:0]     wb_flags;
   logic [3:0]     flags_q;
   logic           illegal;

   int n_run  = 0;
   int n_fail = 0;
   logic [71:0] exp_q [$];

   always #5 clk = ~clk;

   alu_operand_fetch #(.LEN(LEN), .NREG(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .r2(r2), .r3(r3), .rd(rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_flags(wb_flags), .flags_q(flags_q), .illegal(illegal)
   );

   // Scoreboard: every consumed head must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [71:0] got;
         logic [71:0] e;
         got = {opcode, rd, r2, r3};
         n_run++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got=%h want=none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL sb_entry got=%h want=%h", got, e);
            end
         end
      end
   end

   function automatic logic [31:0] mk(input logic [3:0] op,
      input logic [3:0] d, input logic [3:0] s, input logic [3:0] t,
      input logic isel, input logic [14:0] imm);
      return {op, d, s, t, isel, imm};
   endfunction

   function automatic logic [71:0] ent(input logic [3:0] op,
      input logic [3:0] d, input logic [31:0] a, input logic [31:0] b);
      return {op, d, a, b};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] w);
      in_valid = 1'b1;
      instr    = w;
      #1;
   endtask

   task automatic idle;
      in_valid = 1'b0;
      wb_en    = 1'b0;
   endtask

   task automatic wb(input logic [3:0] r, input logic [31:0] d);
      wb_en    = 1'b1;
      wb_rd    = r;
      wb_data  = d;
      wb_flags = 4'd0;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic wait_drain;
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      n_run++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0; wb_flags = '0;
      #12;
      rst_n = 1'b1;
      #1;
      n_run++;
      if ({out_valid, opcode, rd, r2, r3} !== 73'd0) begin
         n_fail++;
         $display("FAIL rst_out got=%h want=0",
                  {out_valid, opcode, rd, r2, r3});
      end
      n_run++;
      if ({in_ready, flags_q, illegal} !== 6'b1_0000_0) begin
         n_fail++;
         $display("FAIL rst_ctl got=%b want=100000",
                  {in_ready, flags_q, illegal});
      end
      tick();
   endtask

   task automatic test_write_read;
      wb(4'd3, 32'h10);
      drive(mk(4'd0, 4'd4, 4'd3, 4'd3, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd0, 4'd4, 32'h10, 32'h10));
      tick();
      idle();
      n_run++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_latency got=%b want=1", out_valid);
      end
      wb(4'd4, 32'h20);
      wait_drain();
   endtask

   task automatic test_imm_r0;
      wb(4'd0, 32'hDEAD);
      wb_en = 1'b1; wb_rd = 4'd0; wb_data = 32'hBEEF;
      drive(mk(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 15'h7FFF));
      exp_q.push_back(ent(4'd1, 4'd1, 32'h0, 32'hFFFF_FFFF));
      tick();
      wb_en = 1'b0;
      drive(mk(4'd5, 4'd2, 4'd0, 4'd0, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd5, 4'd2, 32'h0, 32'h0));
      tick();
      drive(mk(4'd3, 4'd6, 4'd3, 4'd0, 1'b1, 15'd5));
      exp_q.push_back(ent(4'd3, 4'd6, 32'h10, 32'h5));
      tick();
      idle();
      wb(4'd1, 32'h11);
      wb(4'd2, 32'h22);
      wb(4'd6, 32'h66);
      wait_drain();
   endtask

   task automatic test_raw_hazard;
      drive(mk(4'd3, 4'd5, 4'd3, 4'd3, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd3, 4'd5, 32'h10, 32'h10));
      tick();
      drive(mk(4'd4, 4'd7, 4'd5, 4'd3, 1'b0, 15'd0));
      for (int i = 0; i < 2; i++) begin
         n_run++;
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_stall%0d got=%b want=0", i, in_ready);
         end
         tick();
      end
      wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'hA5;
      #1;
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL raw_release got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd4, 4'd7, 32'hA5, 32'h10));
      tick();
      wb_en = 1'b0;
      drive(mk(4'd0, 4'd9, 4'd5, 4'd6, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd0, 4'd9, 32'hA5, 32'h66));
      tick();
      wb_en = 1'b1; wb_rd = 4'd8; wb_data = 32'h77;
      drive(mk(4'd0, 4'd8, 4'd3, 4'd3, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd0, 4'd8, 32'h10, 32'h10));
      tick();
      wb_en = 1'b0;
      drive(mk(4'd0, 4'd10, 4'd8, 4'd3, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL set_wins_rs got=%b want=0", in_ready);
      end
      drive(mk(4'd0, 4'd8, 4'd3, 4'd3, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_rd got=%b want=0", in_ready);
      end
      tick();
      drive(mk(4'd1, 4'd11, 4'd3, 4'd8, 1'b1, 15'd2));
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL imm_masks_rt got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd1, 4'd11, 32'h10, 32'h2));
      tick();
      drive(mk(4'd0, 4'd10, 4'd3, 4'd8, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_rt got=%b want=0", in_ready);
      end
      tick();
      wb_en = 1'b1; wb_rd = 4'd8; wb_data = 32'h99;
      drive(mk(4'd0, 4'd10, 4'd8, 4'd3, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd0, 4'd10, 32'h99, 32'h10));
      tick();
      idle();
      wb(4'd7, 32'h7);
      wb(4'd9, 32'h9);
      wb(4'd10, 32'h10);
      wb(4'd11, 32'h11);
      wait_drain();
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b0;
      drive(mk(4'd2, 4'd12, 4'd3, 4'd6, 1'b0, 15'd0));
      exp_q.push_back(ent(4'd2, 4'd12, 32'h10, 32'h66));
      tick();
      drive(mk(4'd6, 4'd13, 4'd6, 4'd0, 1'b1, 15'd4));
      exp_q.push_back(ent(4'd6, 4'd13, 32'h66, 32'h4));
      tick();
      drive(mk(4'd8, 4'd14, 4'd3, 4'd3, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready got=%b want=0", in_ready);
      end
      tick();
      n_run++;
      if ({out_valid, opcode, r2} !== {1'b1, 4'd2, 32'h10}) begin
         n_fail++;
         $display("FAIL hold_head got=%h want=%h",
                  {out_valid, opcode, r2}, {1'b1, 4'd2, 32'h10});
      end
      in_valid = 1'b0;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_idle_ready got=%b want=0", in_ready);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      n_run++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_oready got=%b want=0", in_ready);
      end
      tick();
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL after_pop got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd8, 4'd14, 32'h10, 32'h10));
      tick();
      idle();
      wait_drain();
      wb(4'd12, 32'h12);
      wb(4'd13, 32'h13);
      wb(4'd14, 32'h14);
   endtask

   task automatic test_illegal_flags;
      drive(mk(4'd12, 4'd15, 4'd3, 4'd3, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ill_ready got=%b want=1", in_ready);
      end
      tick();
      idle();
      n_run++;
      if ({illegal, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL ill_pulse got=%b want=10", {illegal, out_valid});
      end
      tick();
      n_run++;
      if (illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_clear got=%b want=0", illegal);
      end
      drive(mk(4'd0, 4'd14, 4'd3, 4'd15, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ill_no_busy got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd0, 4'd14, 32'h10, 32'h0));
      tick();
      idle();
      wb_en = 1'b1; wb_rd = 4'd14; wb_data = 32'h14; wb_flags = 4'b1010;
      tick();
      wb_en = 1'b0; wb_flags = 4'b0101;
      n_run++;
      if (flags_q !== 4'b1010) begin
         n_fail++;
         $display("FAIL flags_load got=%b want=1010", flags_q);
      end
      tick();
      n_run++;
      if (flags_q !== 4'b1010) begin
         n_fail++;
         $display("FAIL flags_hold got=%b want=1010", flags_q);
      end
      wait_drain();
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      drive(mk(4'd3, 4'd5, 4'd3, 4'd3, 1'b0, 15'd0));
      tick();
      drive(mk(4'd0, 4'd6, 4'd3, 4'd3, 1'b0, 15'd0));
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      n_run++;
      if ({out_valid, in_ready, flags_q} !== {2'b01, 4'd0}) begin
         n_fail++;
         $display("FAIL mid_rst got=%b want=010000",
                  {out_valid, in_ready, flags_q});
      end
      #1;
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      drive(mk(4'd0, 4'd1, 4'd3, 4'd5, 1'b0, 15'd0));
      n_run++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_ready got=%b want=1", in_ready);
      end
      exp_q.push_back(ent(4'd0, 4'd1, 32'h0, 32'h0));
      tick();
      idle();
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_imm_r0();
      test_raw_hazard();
      test_back_to_back();
      test_illegal_flags();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
